// File: rtl/debounce_pkg.sv
// Shared types and default timing constants for the pushbutton debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } db_state_t;

    localparam int CLK_HZ      = 50000000;
    localparam int DEBOUNCE_MS = 1;

    // Converts a debounce window in milliseconds to clock cycles.
    function automatic int cyclesFromMs(input int clkHz, input int ms);
        return (clkHz / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop metastability synchronizer for a single asynchronous bit.
// Resets to 1 so an active-low input reads as inactive.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/key_debouncer.sv
// Synchronizes, debounces and edge-detects one active-low pushbutton.
// Define KEY_REPEAT_EN to emit extra press pulses while the button is held.
module key_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = cyclesFromMs(CLK_HZ, DEBOUNCE_MS),
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_debouncer: illegal parameter value");
    end

    logic             sync_raw;
    logic             sync_key;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             repeat_fire;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (key_n),
        .q_o   (sync_raw)
    );

    assign sync_key = ~sync_raw;

    // A change is accepted only after the synchronized key has disagreed with
    // the debounced level for a full window; any agreeing sample restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sync_key) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!sync_key) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!sync_key) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (sync_key) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [REP_W-1:0] rep_target;
    logic             rep_armed_q, rep_armed_d;

    // The first repeat waits REPEAT_DELAY cycles, later ones REPEAT_PERIOD.
    // Counting only advances across HELD->HELD edges, so RELEASE_WAIT freezes it.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        repeat_fire = 1'b0;
        rep_target  = rep_armed_q ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
        if (state_d == IDLE) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (state_q == HELD && state_d == HELD) begin
            if (rep_cnt_q == rep_target) begin
                repeat_fire = 1'b1;
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    assign pressed_d       = (state_d == HELD) || (state_d == RELEASE_WAIT);
    assign press_pulse_d   = (pressed_d && !pressed_q) || repeat_fire;
    assign release_pulse_d = !pressed_d && pressed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios plus random bouncing,
// compared every cycle against a run-length model of the debounce rules.
module tb_key_debouncer;

    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;

    logic clk = 1'b0;
    logic reset;
    logic key_n;
    logic pressed;
    logic press_pulse;
    logic release_pulse;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int obsPress;
    int obsRelease;

    // Reference model state: delayed key samples, length of the current
    // disagreeing run, and hold time for auto-repeat.
    logic syncPipe[$];
    bit   expPressed;
    bit   expPress;
    bit   expRelease;
    int   run;
    int   heldCnt;

    key_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_n         (key_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        syncPipe = {};
        for (int i = 0; i < SYNC; i++) syncPipe.push_back(1'b1);
        expPressed = 1'b0;
        expPress   = 1'b0;
        expRelease = 1'b0;
        run        = 0;
        heldCnt    = 0;
    endtask

    // A level change is accepted once the synchronized key has disagreed with
    // the debounced level for DB+1 consecutive clock samples.
    task automatic modelStep(input logic k);
        bit syncKey;
        bit wasHeld;
        syncKey = !syncPipe[0];
        void'(syncPipe.pop_front());
        syncPipe.push_back(k);
        wasHeld    = expPressed && (run == 0);
        expPress   = 1'b0;
        expRelease = 1'b0;
        if (syncKey != expPressed) begin
            run++;
            if (run == DB + 1) begin
                expPressed = !expPressed;
                run        = 0;
                if (expPressed) expPress = 1'b1;
                else begin
                    expRelease = 1'b1;
                    heldCnt    = 0;
                end
            end
        end else begin
            run = 0;
        end
`ifdef KEY_REPEAT_EN
        if (wasHeld && expPressed && run == 0) begin
            heldCnt++;
            if (heldCnt >= RD && (heldCnt - RD) % RP == 0) expPress = 1'b1;
        end
`else
        if (wasHeld) heldCnt = 0;
`endif
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (pressed === expPressed) else begin
            errors++;
            $error("FAIL %s.pressed cycle %0d: observed %b expected %b", tag, cycle, pressed, expPressed);
        end
        checks++;
        assert (press_pulse === expPress) else begin
            errors++;
            $error("FAIL %s.press_pulse cycle %0d: observed %b expected %b", tag, cycle, press_pulse, expPress);
        end
        checks++;
        assert (release_pulse === expRelease) else begin
            errors++;
            $error("FAIL %s.release_pulse cycle %0d: observed %b expected %b", tag, cycle, release_pulse, expRelease);
        end
        checks++;
        assert ((press_pulse & release_pulse) === 1'b0) else begin
            errors++;
            $error("FAIL %s.both_pulses cycle %0d: observed %b expected 0", tag, cycle, press_pulse & release_pulse);
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check just after the rising edge.
    task automatic applyStimulus(input logic k, input logic r, input string tag);
        @(negedge clk);
        key_n = k;
        reset = r;
        if (r) modelReset();
        @(posedge clk);
        if (!r) modelStep(k);
        #1;
        checkOutput(tag);
        if (press_pulse === 1'b1) obsPress++;
        if (release_pulse === 1'b1) obsRelease++;
        cycle++;
    endtask

    initial begin
        int   edgeSeen;
        int   len;
        logic lvl;

        reset = 1'b1;
        key_n = 1'b1;
        modelReset();
        obsPress   = 0;
        obsRelease = 0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, "reset");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, "idle");
        checkValue("idle_press_count", obsPress, 0);
        checkValue("idle_release_count", obsRelease, 0);

        obsPress = 0;
        edgeSeen = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, "press");
            if (press_pulse === 1'b1 && edgeSeen < 0) edgeSeen = i;
        end
        checkValue("press_latency", edgeSeen, SYNC + DB);
        checkValue("press_count", obsPress, 1);

        obsPress   = 0;
        obsRelease = 0;
        for (int i = 0; i < 12; i++) applyStimulus(((i / 2) % 2 == 0) ? 1'b1 : 1'b0, 1'b0, "glitch");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, "glitch_hold");
        checkValue("glitch_release_count", obsRelease, 0);
        checkValue("glitch_pressed", int'(pressed), 1);
`ifndef KEY_REPEAT_EN
        checkValue("glitch_press_count", obsPress, 0);
`endif

        obsRelease = 0;
        edgeSeen   = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, "release");
            if (release_pulse === 1'b1 && edgeSeen < 0) edgeSeen = i;
        end
        checkValue("release_latency", edgeSeen, SYNC + DB);
        checkValue("release_count", obsRelease, 1);

        obsPress = 0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, "short_press");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, "short_release");
        checkValue("short_press_count", obsPress, 0);
        checkValue("short_pressed", int'(pressed), 0);

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, "pre_reset");
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, "mid_reset");
        obsPress = 0;
        edgeSeen = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, "post_reset");
            if (press_pulse === 1'b1 && edgeSeen < 0) edgeSeen = i;
        end
        checkValue("post_reset_latency", edgeSeen, SYNC + DB);
        checkValue("post_reset_count", obsPress, 1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, "post_reset_release");

        obsPress = 0;
        edgeSeen = -1;
        for (int i = 0; i < SYNC + DB + 31; i++) begin
            applyStimulus(1'b0, 1'b0, "long_hold");
            if (press_pulse === 1'b1 && edgeSeen < 0) edgeSeen = i;
        end
        checkValue("long_hold_rise", edgeSeen, SYNC + DB);
`ifdef KEY_REPEAT_EN
        checkValue("long_hold_pulses", obsPress, 8);
`else
        checkValue("long_hold_pulses", obsPress, 1);
`endif
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, "long_release");

        for (int n = 0; n < 60; n++) begin
            len = $urandom_range(1, 10);
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) applyStimulus(lvl, 1'b1, "rand_reset");
            for (int j = 0; j < len; j++) applyStimulus(lvl, 1'b0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
